led_sequencer: RTL

Parametrised RGB/LED colour sequencer that drives the memory-mapped LED register through the data-memory store port. It replaces the hard-wired six-colour dwell loop in the top level. It adds:
- a configurable step count and colour table;
- a run-time loadable dwell time;
- loop, ping-pong, one-shot and hold modes, with single-step;
- a one-cycle write strobe per colour change instead of a permanently asserted write enable.

It sits between the top level and `memory`, owning `dmem_wren`/`dmem_address`/`dmem_data_in`/`funct3` while the CPU datapath is not yet storing.

---
 rtl/led_seq_pkg.sv | 29 ++
 rtl/led_sequencer_if.sv | 23 ++
 rtl/dwell_timer.sv | 32 +++
 rtl/led_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types and constants for the LED colour sequencer
// Contents: FSM state and mode enums, store-width/LED-address constants,
// default six-colour table (index 0 in the most significant word).
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } led_seq_state_t;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'b00,
        MODE_PINGPONG = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_HOLD     = 2'b11
    } led_seq_mode_t;

    localparam logic [2:0]  FUNCT3_SW     = 3'b010;
    localparam logic [31:0] LED_MMIO_ADDR = 32'hFFFF_FFFC;

    localparam int DEFAULT_NUM_STEPS = 6;
    localparam logic [DEFAULT_NUM_STEPS*32-1:0] DEFAULT_STEP_COLORS = {
        32'hFFFF_0000, 32'hFFFF_FF00, 32'hFF00_FF00,
        32'h0000_FFFF, 32'h0000_00FF, 32'h00FF_00FF
    };

endpackage

// File: rtl/led_sequencer_if.sv
// rtl/led_sequencer_if.sv - data-memory store port driven by the LED sequencer
// Signals: dmem_wren (store strobe), dmem_address, dmem_data_in, funct3.
// master: the sequencer (drives); slave: the memory (receives).
interface led_sequencer_if;
    logic        dmem_wren;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [2:0]  funct3;

    modport master (
        output dmem_wren,
        output dmem_address,
        output dmem_data_in,
        output funct3
    );

    modport slave (
        input dmem_wren,
        input dmem_address,
        input dmem_data_in,
        input funct3
    );
endinterface

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable, freezable dwell down-counter
// Ports: clk, reset (sync active-low), load/load_value (reload, wins over
// counting), enable (count when high, freeze when low), expired (current
// cycle is the last dwell cycle, or the count is already exhausted).
module dwell_timer #(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    // A count of N gives N dwell cycles: the cycle holding 1 is the last.
    // Zero also reports expired so a count frozen at 0 by hold advances on release.
    assign expired = (count <= WIDTH'(1));

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - parametrised LED colour sequencer driving the LED store port
// Ports: clk, reset (sync active-low), enable, mode (00 loop, 01 ping-pong,
// 10 one-shot, 11 hold), step_req, dwell_load/dwell_value, store (master
// store port), step_index, done. All outputs registered.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int                      NUM_STEPS     = DEFAULT_NUM_STEPS,
    parameter int                      DWELL_WIDTH   = 22,
    parameter int                      DWELL_DEFAULT = 3000000,
    parameter logic [31:0]             LED_ADDR      = LED_MMIO_ADDR,
    parameter logic [NUM_STEPS*32-1:0] STEP_COLORS   = DEFAULT_STEP_COLORS,
    localparam int                     IDX_W         = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic                   step_req,
    input  logic                   dwell_load,
    input  logic [DWELL_WIDTH-1:0] dwell_value,
    led_sequencer_if.master        store,
    output logic [IDX_W-1:0]       step_index,
    output logic                   done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

    led_seq_state_t   state;
    led_seq_mode_t    mode_e;
    logic             dir_up;
    logic [DWELL_WIDTH-1:0] dwell_reg;
    logic [DWELL_WIDTH-1:0] load_value;
    logic             timer_load;
    logic             timer_en;
    logic             timer_expired;
    logic             do_advance;
    logic [IDX_W-1:0] adv_idx;
    logic             adv_up;
    logic             adv_done;
    logic [31:0]      color_tab [NUM_STEPS];

    assign mode_e = led_seq_mode_t'(mode);

    // Colour table is given most-significant word first, so index 0 is the top word.
    for (genvar g = 0; g < NUM_STEPS; g++) begin : g_color
        assign color_tab[g] = STEP_COLORS[(NUM_STEPS-1-g)*32 +: 32];
    end

    // A dwell_load coinciding with WRITE feeds the new value straight into the counter.
    assign load_value = dwell_load ? dwell_value : dwell_reg;
    assign timer_load = enable && (state == ST_WRITE);
    assign timer_en   = enable && (state == ST_DWELL) && (mode_e != MODE_HOLD);

    dwell_timer #(
        .WIDTH (DWELL_WIDTH)
    ) u_dwell_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (load_value),
        .enable     (timer_en),
        .expired    (timer_expired)
    );

    // Advance happens straight out of WRITE when there is no dwell (except in
    // hold, which only ever moves on step_req), or at the end of DWELL.
    always_comb begin
        do_advance = 1'b0;
        if (enable) begin
            case (state)
                ST_WRITE: do_advance = (load_value == '0) && (mode_e != MODE_HOLD);
                ST_DWELL: do_advance = (mode_e == MODE_HOLD) ? step_req : timer_expired;
                default:  do_advance = 1'b0;
            endcase
        end
    end

    // Next index/direction for one advance; hold uses the loop rule.
    always_comb begin
        adv_idx  = step_index;
        adv_up   = dir_up;
        adv_done = 1'b0;
        case (mode_e)
            MODE_PINGPONG: begin
                if (NUM_STEPS > 1) begin
                    // Reverse on the same advance so the end steps are not repeated.
                    if (step_index == LAST_IDX) begin
                        adv_up = 1'b0;
                    end else if (step_index == '0) begin
                        adv_up = 1'b1;
                    end
                    adv_idx = adv_up ? step_index + IDX_W'(1) : step_index - IDX_W'(1);
                end
            end
            MODE_ONESHOT: begin
                if (step_index == LAST_IDX) begin
                    adv_done = 1'b1;
                end else begin
                    adv_idx = step_index + IDX_W'(1);
                end
            end
            default: begin
                adv_idx = (step_index == LAST_IDX) ? '0 : step_index + IDX_W'(1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= ST_IDLE;
            step_index         <= '0;
            dir_up             <= 1'b1;
            dwell_reg          <= DWELL_WIDTH'(DWELL_DEFAULT);
            done               <= 1'b0;
            store.dmem_wren    <= 1'b0;
            store.dmem_address <= LED_ADDR;
            store.dmem_data_in <= '0;
            store.funct3       <= FUNCT3_SW;
        end else begin
            if (dwell_load) begin
                dwell_reg <= dwell_value;
            end
            store.dmem_wren <= 1'b0;

            if (!enable) begin
                state      <= ST_IDLE;
                step_index <= '0;
                dir_up     <= 1'b1;
                done       <= 1'b0;
            end else if (do_advance) begin
                if (adv_done) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end else begin
                    state              <= ST_WRITE;
                    step_index         <= adv_idx;
                    dir_up             <= adv_up;
                    store.dmem_wren    <= 1'b1;
                    store.dmem_data_in <= color_tab[adv_idx];
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        state              <= ST_WRITE;
                        store.dmem_wren    <= 1'b1;
                        store.dmem_data_in <= color_tab[step_index];
                    end
                    ST_WRITE: state <= ST_DWELL;
                    ST_DWELL: state <= ST_DWELL;
                    ST_DONE: begin
                        // Leaving one-shot restarts the sequence from the first colour.
                        if (mode_e != MODE_ONESHOT) begin
                            state              <= ST_WRITE;
                            step_index         <= '0;
                            done               <= 1'b0;
                            store.dmem_wren    <= 1'b1;
                            store.dmem_data_in <= color_tab[0];
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
